midi_tx_queue: RTL
==================

# midi_tx_queue

Per-port MIDI transmit stage between the router core and the output jack. It accepts one byte per clock from the router's `txdv`/`txdata` strobe, buffers bytes in a small FIFO and serialises them as 31250-baud 8N1 MIDI frames. It also drives a stretched activity flag for the front-panel LED. The router can emit a byte every cycle, for example during reset broadcasts or config dumps, so this queue absorbs those bursts. Bytes that arrive while the queue is full are counted and dropped.

## Interface

**Parameters**
- `CLOCK`, 12_000_000, system clock frequency in Hz.
- `BAUD`, 31250, serial bit rate. `BIT_CLKS = CLOCK/BAUD`, integer-truncated; this is 384 at the defaults.
- `DEPTH`, 16, FIFO depth in bytes. Must be a power of 2 and at least 2.
- `ACT_CLKS`, CLOCK/20, activity hold time after the last stop bit (50 ms at the defaults).

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-low.
- `txdv`  in  1  write strobe; one byte per asserted cycle.
- `txdata`  in  8  byte to queue.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  one-cycle pulse for each dropped write.
- `drop_count`  out  8  dropped-byte count, saturating at 255.
- `outport`  out  1  serial MIDI output; idles high.
- `activity_out`  out  1  stretched transmit-activity flag.

## Operation

**Reset values** (`rst`=0 at a clock edge)
- `outport`=1, `activity_out`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `drop_count`=0.
- FIFO pointers are cleared and the serialiser enters IDLE.
- Reset mid-frame aborts the frame. `outport` is 1 at the next edge and no partial frame resumes.

**Write**
- A write is accepted when `txdv`=1 and the registered `full`=0.
- When `full`=1, the byte is discarded, `overflow` pulses on the next cycle and `drop_count` increments.
- A write while full is dropped even if a pop happens in the same cycle. `full` is the only admission test.

**Pop**
- The serialiser pops the head byte when it is in IDLE with `empty`=0, or in the last cycle of STOP with `empty`=0.
- Write and pop in the same cycle leave `level` unchanged.

**Serialiser FSM** (bit counter 0..BIT_CLKS-1, data-bit index 0..7)
- IDLE: `outport`=1. On pop, go to START.
- START: `outport`=0 for BIT_CLKS clocks, then go to DATA.
- DATA: shift out 8 bits LSB first, each held BIT_CLKS clocks, then go to STOP.
- STOP: `outport`=1 for BIT_CLKS clocks. At the last cycle, pop and go to START if not empty, otherwise go to IDLE.

**Activity stretch**
- `activity_out`=1 while the FSM is not in IDLE.
- After the FSM returns to IDLE, it stays 1 for ACT_CLKS further clocks. A new frame retriggers it.

## Timing

- Write to start bit: `txdv` is sampled at edge N into an empty FIFO with the FSM idle. `level`=1 after edge N, the pop occurs in cycle N+1, and `outport` falls after edge N+2 (2-cycle latency).
- Frame length is exactly 10·BIT_CLKS clocks.
- Back-to-back frames have zero idle gap. Frame period is 10·BIT_CLKS while the queue is non-empty.
- `full`, `empty` and `level` are registered and update the cycle after a write or pop.
- `drop_count` saturates at 255 and does not wrap. `overflow` still pulses after saturation.
- FIFO pointers wrap modulo DEPTH. `level` distinguishes full from empty.

## Structure

- Shared package `midi_pkg` holds:
  - the `BAUD` default 31250;
  - the `bit_clks(CLOCK, BAUD)` function;
  - the serialiser state typedef {IDLE, START, DATA, STOP};
  - the MIDI status constants (0xF0, 0xF7, 0xF8, 0xFC, 0xFE).
- Sub-module `midi_byte_fifo` (params DEPTH, WIDTH=8) provides the synchronous FIFO with `full`/`empty`/`level`.
- Serialiser, drop counter and activity stretcher live in `midi_tx_queue`.

## Test plan

Defaults apply unless a scenario states otherwise (BIT_CLKS=384).

1. Reset: hold `rst`=0 for 1 cycle with `txdv`=1 → `outport`=1, `empty`=1, `level`=0, `activity_out`=0, `drop_count`=0, and no frame starts.
2. Single byte 0x90 → `outport` low at write+2 for 384 clocks, then data bits 0,0,0,0,1,0,0,1 at 384 clocks each, then stop high. The FSM is back in IDLE 3840 clocks after the start bit.
3. Burst 0xF0, 0x7D, 0xF7 on consecutive cycles → three contiguous frames totalling 11520 clocks with no high gap beyond the stop bits. `level` peaks at 2.
4. Overflow: 20 consecutive writes of 0x00..0x13 (DEPTH=16) → byte 0x00 is popped at cycle 1, and 0x11, 0x12, 0x13 are dropped. Result: `drop_count`=3, 3 `overflow` pulses, and 0x00..0x10 transmitted in order.
5. Reset mid-frame: assert `rst` during data bit 3 of the second queued byte → `outport`=1 the next cycle and `level`=0. A subsequent write of 0x55 transmits cleanly with 2-cycle latency.
6. Activity (ACT_CLKS=1000): one byte → `activity_out` high from the pop through 3840+1000 clocks. A second byte written 500 clocks after the frame ends retriggers the flag with no low glitch.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, bit-timing helper and serialiser state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  // Status bytes the router commonly emits in bursts.
  localparam logic [7:0] MIDI_SYSEX_START  = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_END    = 8'hF7;
  localparam logic [7:0] MIDI_TIMING_CLOCK = 8'hF8;
  localparam logic [7:0] MIDI_STOP         = 8'hFC;
  localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

  // Clocks per serial bit, integer-truncated.
  function automatic int bit_clks(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: synchronous first-word-fall-through FIFO with registered full/empty/level.
// Latency: written word visible at rd_data one clock after the write; flags update the cycle after.
// Backpressure: writes while full are ignored; reads while empty are ignored.
module midi_byte_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Admission looks only at the registered full flag, so a same-cycle pop never frees a slot.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this clock; simultaneous write and read cancel.
  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok) begin
      level_nxt = level + LW'(1);
    end else if (!wr_ok && rd_ok) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap modulo DEPTH; level tells full apart from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/midi_tx_queue.sv
// midi_tx_queue: buffers router bytes and serialises them as 8N1 MIDI frames, plus a stretched activity flag.
// Latency: a byte written into an idle, empty queue starts its start bit two clocks later; frames run back to back.
// Backpressure: none toward the router; writes while full are dropped, pulsed on overflow and counted.
module midi_tx_queue
  import midi_pkg::*;
#(
  parameter int CLOCK    = 12_000_000,
  parameter int BAUD     = MIDI_BAUD,
  parameter int DEPTH    = 16,
  parameter int ACT_CLKS = CLOCK / 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   txdv,
  input  logic [7:0]             txdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic                   outport,
  output logic                   activity_out
);

  localparam int BIT_CLKS = bit_clks(CLOCK, BAUD);
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int ACT_W    = (ACT_CLKS > 0) ? $clog2(ACT_CLKS + 1) : 1;

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     bit_cnt_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_nxt;
  logic [7:0]        shreg;
  logic [7:0]        fifo_dat;
  logic              pop;
  logic              bit_last;
  logic              line_nxt;
  logic [ACT_W-1:0]  hold_cnt;

  midi_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (txdv),
    .wr_data (txdata),
    .rd_en   (pop),
    .rd_data (fifo_dat),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign bit_last = (bit_cnt == CW'(BIT_CLKS - 1));

  // Serialiser next state, bit timing, pop request and the line level for the current state.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    line_nxt    = 1'b1;
    case (state)
      IDLE: begin
        line_nxt = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        line_nxt = 1'b0;
        if (bit_last) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      DATA: begin
        line_nxt = shreg[bit_idx];
        if (bit_last) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      STOP: begin
        line_nxt = 1'b1;
        if (bit_last) begin
          bit_cnt_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serialiser registers; outport is registered so the line is glitch-free and lags state by one clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      outport <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      outport <= line_nxt;
      if (pop) shreg <= fifo_dat;
    end
  end

  // Drop accounting: one pulse per rejected write, count saturates at 255.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= txdv && full;
      if (txdv && full && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Activity hold: reloaded while a frame is on the wire, counts down once idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state != IDLE) begin
      hold_cnt <= ACT_W'(ACT_CLKS);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - ACT_W'(1);
    end
  end

  assign activity_out = (state != IDLE) || (hold_cnt != '0);

endmodule
